ysyx_24110015_forward_scoreboard: RTL and testbench

//  Parametrised RAW-hazard/bypass unit between IDU and the in-order back end (EXU/LSU/WBU...).

---
 rtl/ysyx_24110015_forward_scoreboard_if.sv | 28 ++
 rtl/ysyx_24110015_forward_scoreboard.sv | 131 +++++++++++++
 tb/tb_ysyx_24110015_forward_scoreboard.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24110015_forward_scoreboard_if.sv
// Decode-side issue handshake and per-port forwarding results shared by the IDU
// and the bypass/scoreboard unit.
interface ysyx_24110015_forward_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2
);
  localparam int AW = $clog2(NREG);

  logic                 id_valid;
  logic                 id_ready;
  logic [NRP-1:0]       id_rs_en;
  logic [NRP*AW-1:0]    id_rs_addr;
  logic                 id_wen;
  logic [AW-1:0]        id_rd;
  logic [NRP-1:0]       fwd_hit;
  logic [NRP*XLEN-1:0]  fwd_data;

  modport master (
    output id_valid, id_rs_en, id_rs_addr, id_wen, id_rd,
    input  id_ready, fwd_hit, fwd_data
  );

  modport slave (
    input  id_valid, id_rs_en, id_rs_addr, id_wen, id_rd,
    output id_ready, fwd_hit, fwd_data
  );
endinterface

// File: rtl/ysyx_24110015_forward_scoreboard.sv
// RAW-hazard bypass unit: picks the youngest matching forwarding tap per read port
// and keeps a per-register in-flight writer count so untapped producers still stall issue.
module ysyx_24110015_forward_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int NSTG = 3,
  parameter int CNTW = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ysyx_24110015_forward_scoreboard_if.slave id_if,
  input  logic [NSTG-1:0]        i_stg_valid,
  input  logic [NSTG-1:0]        i_stg_wen,
  input  logic [NSTG*$clog2(NREG)-1:0] i_stg_waddr,
  input  logic [NSTG-1:0]        i_stg_rdy,
  input  logic [NSTG*XLEN-1:0]   i_stg_data,
  input  logic                   i_wb_retire,
  input  logic [$clog2(NREG)-1:0] i_wb_rd,
  input  logic                   i_flush,
  output logic                   o_stall,
  output logic                   o_sb_err,
  output logic [31:0]            o_stall_cycles
);
  localparam int AW = $clog2(NREG);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [NREG-1:0][CNTW-1:0] r_cnt;
  logic                      r_sb_err;
  logic [31:0]               r_stall_cycles;

  logic [NRP-1:0][AW-1:0]    w_addr;
  logic [NRP-1:0]            w_any;
  logic [NRP-1:0]            w_wrdy;
  logic [NRP-1:0][XLEN-1:0]  w_wdata;
  logic [NRP-1:0]            w_chk;
  logic [NRP-1:0]            w_haz;
  logic [NRP-1:0]            w_hit;
  logic [NRP*XLEN-1:0]       w_fwd_data;
  logic                      w_m;
  logic                      w_stall;
  logic                      w_full;
  logic                      w_issue;
  logic [NREG-1:0][CNTW-1:0] w_cnt_nxt;
  logic                      w_err_set;
  logic                      w_inc;
  logic                      w_dec;

  // Tap match per port; scanning oldest to youngest lets the youngest match win.
  always_comb begin
    w_addr     = '0;
    w_any      = '0;
    w_wrdy     = '0;
    w_wdata    = '0;
    w_chk      = '0;
    w_haz      = '0;
    w_hit      = '0;
    w_fwd_data = '0;
    w_m        = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      w_addr[p] = id_if.id_rs_addr[p*AW +: AW];
      for (int s = NSTG - 1; s >= 0; s--) begin
        w_m = i_stg_valid[s] & i_stg_wen[s] & (i_stg_waddr[s*AW +: AW] == w_addr[p]);
        w_any[p]   = w_any[p] | w_m;
        w_wrdy[p]  = w_m ? i_stg_rdy[s] : w_wrdy[p];
        w_wdata[p] = w_m ? i_stg_data[s*XLEN +: XLEN] : w_wdata[p];
      end
      w_chk[p] = id_if.id_valid & id_if.id_rs_en[p] & (w_addr[p] != {AW{1'b0}});
      w_haz[p] = w_any[p] ? ~w_wrdy[p] : (r_cnt[w_addr[p]] != {CNTW{1'b0}});
      w_hit[p] = w_chk[p] & w_any[p] & w_wrdy[p];
      w_fwd_data[p*XLEN +: XLEN] = w_hit[p] ? w_wdata[p] : {XLEN{1'b0}};
    end
  end

  assign w_stall = |(w_chk & w_haz);
  assign w_full  = id_if.id_wen & (id_if.id_rd != {AW{1'b0}}) & (r_cnt[id_if.id_rd] == CNT_MAX);
  assign w_issue = id_if.id_valid & ~w_stall & ~w_full;

  assign id_if.id_ready  = ~w_stall & ~w_full;
  assign id_if.fwd_hit   = w_hit;
  assign id_if.fwd_data  = w_fwd_data;
  assign o_stall         = w_stall;
  assign o_sb_err        = r_sb_err;
  assign o_stall_cycles  = r_stall_cycles;

  // Next in-flight count per register; x0 never tracks a writer.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_err_set = 1'b0;
    w_inc     = 1'b0;
    w_dec     = 1'b0;
    w_cnt_nxt[0] = {CNTW{1'b0}};
    for (int r = 1; r < NREG; r++) begin
      w_inc = w_issue & id_if.id_wen & (id_if.id_rd == AW'(r));
      w_dec = i_wb_retire & (i_wb_rd == AW'(r));
      // A retire with nothing in flight means the bookkeeping went wrong upstream.
      w_err_set = w_err_set | (w_dec & (r_cnt[r] == {CNTW{1'b0}}));
      case ({w_inc, w_dec})
        2'b10:   w_cnt_nxt[r] = r_cnt[r] + CNTW'(1);
        2'b01:   w_cnt_nxt[r] = (r_cnt[r] == {CNTW{1'b0}}) ? r_cnt[r] : r_cnt[r] - CNTW'(1);
        default: w_cnt_nxt[r] = r_cnt[r];
      endcase
    end
  end

  // Scoreboard counters; flush drops every in-flight writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Sticky error flag and saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_err       <= 1'b0;
      r_stall_cycles <= 32'd0;
    end else begin
      r_sb_err <= r_sb_err | w_err_set;
      if (id_if.id_valid && w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_24110015_forward_scoreboard.sv
// Directed bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_ysyx_24110015_forward_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NSTG = 3;
  localparam int CNTW = 2;
  localparam int AW   = 5;

  typedef struct {
    string       nm;
    logic        stall;
    logic        ready;
    logic [1:0]  hit;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        err;
    logic [31:0] sc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [NSTG-1:0]      stg_valid;
  logic [NSTG-1:0]      stg_wen;
  logic [NSTG*AW-1:0]   stg_waddr;
  logic [NSTG-1:0]      stg_rdy;
  logic [NSTG*XLEN-1:0] stg_data;
  logic                 wb_retire;
  logic [AW-1:0]        wb_rd;
  logic                 flush;
  logic                 stall;
  logic                 sb_err;
  logic [31:0]          stall_cycles;

  exp_t q[$];
  int   total;
  int   bad;

  ysyx_24110015_forward_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) sb_if ();

  ysyx_24110015_forward_scoreboard #(
    .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NSTG(NSTG), .CNTW(CNTW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_if          (sb_if),
    .i_stg_valid    (stg_valid),
    .i_stg_wen      (stg_wen),
    .i_stg_waddr    (stg_waddr),
    .i_stg_rdy      (stg_rdy),
    .i_stg_data     (stg_data),
    .i_wb_retire    (wb_retire),
    .i_wb_rd        (wb_rd),
    .i_flush        (flush),
    .o_stall        (stall),
    .o_sb_err       (sb_err),
    .o_stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s: got %h want %h", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so each pending expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.nm, "stall", {31'd0, stall}, {31'd0, e.stall});
      cmp(e.nm, "ready", {31'd0, sb_if.id_ready}, {31'd0, e.ready});
      cmp(e.nm, "hit", {30'd0, sb_if.fwd_hit}, {30'd0, e.hit});
      cmp(e.nm, "d0", sb_if.fwd_data[31:0], e.d0);
      cmp(e.nm, "d1", sb_if.fwd_data[63:32], e.d1);
      cmp(e.nm, "err", {31'd0, sb_err}, {31'd0, e.err});
      cmp(e.nm, "sc", stall_cycles, e.sc);
    end
  end

  task automatic push(input string nm, input logic st, input logic rd, input logic [1:0] h,
                      input logic [31:0] d0, input logic [31:0] d1, input logic err,
                      input logic [31:0] sc);
    exp_t e;
    e.nm = nm; e.stall = st; e.ready = rd; e.hit = h;
    e.d0 = d0; e.d1 = d1; e.err = err; e.sc = sc;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.id_valid   = 1'b0;
    sb_if.id_rs_en   = 2'b00;
    sb_if.id_rs_addr = '0;
    sb_if.id_wen     = 1'b0;
    sb_if.id_rd      = 5'd0;
    stg_valid = 3'b000; stg_wen = 3'b000; stg_waddr = '0; stg_rdy = 3'b000; stg_data = '0;
    wb_retire = 1'b0; wb_rd = 5'd0; flush = 1'b0;
  endtask

  task automatic set_tap(input int s, input logic [4:0] a, input logic rdy, input logic [31:0] d);
    stg_valid[s] = 1'b1;
    stg_wen[s]   = 1'b1;
    stg_waddr[s*AW +: AW] = a;
    stg_rdy[s]   = rdy;
    stg_data[s*XLEN +: XLEN] = d;
  endtask

  task automatic rd_ports(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
    sb_if.id_valid   = 1'b1;
    sb_if.id_rs_en   = en;
    sb_if.id_rs_addr = {a1, a0};
  endtask

  task automatic wr(input logic [4:0] rd);
    sb_if.id_valid = 1'b1;
    sb_if.id_wen   = 1'b1;
    sb_if.id_rd    = rd;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    rst_n = 1'b0;
    push("reset", 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;

    rd_ports(2'b01, 5'd5, 5'd0);
    push("rf_read", 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 32'd0);
    cyc();

    set_tap(0, 5'd5, 1'b1, 32'h0000_1234);
    set_tap(1, 5'd5, 1'b1, 32'h0000_AAAA);
    push("youngest", 1'b0, 1'b1, 2'b01, 32'h0000_1234, 32'd0, 1'b0, 32'd0);
    cyc();

    idle(); rd_ports(2'b01, 5'd5, 5'd0);
    set_tap(0, 5'd5, 1'b0, 32'h0000_1234);
    push("pend0", 1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 32'd0);
    cyc();
    push("pend1", 1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 32'd1);
    cyc();
    stg_rdy[0] = 1'b1;
    push("pend_done", 1'b0, 1'b1, 2'b01, 32'h0000_1234, 32'd0, 1'b0, 32'd2);
    cyc();

    idle(); rd_ports(2'b11, 5'd0, 5'd6);
    set_tap(0, 5'd0, 1'b1, 32'h0000_DEAD);
    set_tap(2, 5'd6, 1'b1, 32'h0000_6666);
    push("x0_tap2", 1'b0, 1'b1, 2'b10, 32'd0, 32'h0000_6666, 1'b0, 32'd2);
    cyc();

    // x7 counts 0->1->2, held at 2 by issue+retire, then 3; a fourth writer must wait.
    idle(); wr(5'd7);
    push("wr7_a", 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 32'd2);
    cyc();
    push("wr7_b", 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 32'd2);
    cyc();
    wb_retire = 1'b1; wb_rd = 5'd7;
    push("wr7_hold", 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 32'd2);
    cyc();
    wb_retire = 1'b0;
    push("wr7_c", 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 32'd2);
    cyc();
    push("wr7_full", 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 32'd2);
    cyc();
    idle(); rd_ports(2'b01, 5'd7, 5'd0);
    push("rd7_inflight", 1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 32'd2);
    cyc();

    idle(); wb_retire = 1'b1; wb_rd = 5'd9;
    push("ret9", 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 32'd3);
    cyc();
    idle();
    push("err_sticky", 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b1, 32'd3);
    cyc();
    flush = 1'b1;
    push("flush", 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b1, 32'd3);
    cyc();
    idle(); rd_ports(2'b01, 5'd7, 5'd0);
    push("rd7_flushed", 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b1, 32'd3);
    cyc();
    idle(); wr(5'd7);
    push("wr7_after", 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b1, 32'd3);
    cyc();

    // Mid-run reset clears the x7 writer, sb_err and stall_cycles at once.
    idle(); rd_ports(2'b10, 5'd0, 5'd7);
    push("rd7_again", 1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd3);
    cyc();
    rst_n = 1'b0;
    push("mid_reset", 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 32'd0);
    cyc();
    rst_n = 1'b1;

    idle(); rd_ports(2'b10, 5'd0, 5'd10);
    set_tap(1, 5'd10, 1'b0, 32'h0000_1111);
    set_tap(2, 5'd10, 1'b1, 32'h0000_2222);
    push("young_pending", 1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 32'd0);
    cyc();
    idle();
    push("sc_after", 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 32'd1);
    cyc();

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
